// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stages: ALU opcode encodings, field
// widths and the data-source select encoding used by the operand-B mux.
// Optional feature macro used by importers: ALU_OVF_EN (signed overflow flag).
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int IMM_W    = 16;
  localparam int REGSEL_W = 5;

  localparam logic DS_REG = 1'b0;
  localparam logic DS_IMM = 1'b1;

  localparam logic [2:0] ALU_MOV = 3'b000;
  localparam logic [2:0] ALU_NOT = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/stage3_execute_if.sv
// ---------------------------------------------------------------------------
// stage3_execute_if
// Bundles the Stage2 -> Stage3 operand/control signals and the Stage3
// register-file write port outputs.
//   master : Stage2 side, drives WriteEnable and S2_*, observes S3_*.
//   slave  : Stage3 execute, consumes S2_*, drives S3_* and RetireCount.
// Optional feature macro: ALU_OVF_EN adds S3_Ovf.
// ---------------------------------------------------------------------------
interface stage3_execute_if #(
  parameter int N     = 32,
  parameter int CNT_W = 32
);
  import pipe_pkg::*;

  logic                WriteEnable;
  logic [N-1:0]        S2_RD1;
  logic [N-1:0]        S2_RD2;
  logic [IMM_W-1:0]    S2_IMM;
  logic                S2_DS;
  logic [2:0]          S2_ALUOp;
  logic [REGSEL_W-1:0] S2_WS;
  logic                S2_WE;

  logic [N-1:0]        S3_ALUOut;
  logic [REGSEL_W-1:0] S3_WS;
  logic                S3_WE;
  logic                S3_Zero;
  logic [CNT_W-1:0]    RetireCount;
`ifdef ALU_OVF_EN
  logic                S3_Ovf;
`endif

  modport master (
    output WriteEnable, S2_RD1, S2_RD2, S2_IMM, S2_DS, S2_ALUOp, S2_WS, S2_WE,
    input  S3_ALUOut, S3_WS, S3_WE, S3_Zero, RetireCount
`ifdef ALU_OVF_EN
    , input S3_Ovf
`endif
  );

  modport slave (
    input  WriteEnable, S2_RD1, S2_RD2, S2_IMM, S2_DS, S2_ALUOp, S2_WS, S2_WE,
    output S3_ALUOut, S3_WS, S3_WE, S3_Zero, RetireCount
`ifdef ALU_OVF_EN
    , output S3_Ovf
`endif
  );

endinterface

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational N-bit ALU.
// Ports:
//   A, B    : operands (two's complement where signedness matters)
//   ALUOp   : operation code (pipe_pkg ALU_* encodings)
//   Result  : operation result, N bits, arithmetic wraps modulo 2^N
//   Zero    : 1 when Result is all zeros
//   Ovf     : signed overflow for ADD/SUB, only present with ALU_OVF_EN
// Optional feature macro: ALU_OVF_EN.
// ---------------------------------------------------------------------------
module alu_core
  import pipe_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   ALUOp,
  output logic [N-1:0] Result,
  output logic         Zero
`ifdef ALU_OVF_EN
  , output logic       Ovf
`endif
);

  logic [N-1:0] sum;
  logic [N-1:0] diff;
  logic         less;

  assign sum  = A + B;
  assign diff = A - B;
  assign less = $signed(A) < $signed(B);

  always_comb begin
    Result = '0;
    unique case (ALUOp)
      ALU_MOV: Result = A;
      ALU_NOT: Result = ~A;
      ALU_ADD: Result = sum;
      ALU_SUB: Result = diff;
      ALU_OR:  Result = A | B;
      ALU_AND: Result = A & B;
      ALU_XOR: Result = A ^ B;
      ALU_SLT: Result = {{(N-1){1'b0}}, less};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

`ifdef ALU_OVF_EN
  // Overflow only when the true signed result leaves the N-bit range, which
  // shows up as the result sign disagreeing with the operand signs.
  always_comb begin
    Ovf = 1'b0;
    if (ALUOp == ALU_ADD)
      Ovf = (A[N-1] == B[N-1]) && (sum[N-1] != A[N-1]);
    else if (ALUOp == ALU_SUB)
      Ovf = (A[N-1] != B[N-1]) && (diff[N-1] != A[N-1]);
  end
`endif

endmodule

// File: rtl/stage3_execute.sv
// ---------------------------------------------------------------------------
// stage3_execute
// Execute/writeback stage: selects operand B, runs the ALU and registers the
// result into the Stage3 register that drives the register-file write port.
// Also keeps a wrapping count of register writes loaded into Stage3.
// Ports:
//   Clk   : pipeline clock, all state updates on posedge
//   Reset : synchronous active-high clear, wins over WriteEnable
//   bus   : stage3_execute_if.slave (WriteEnable, S2_* in; S3_*, RetireCount out)
// Optional feature macro: ALU_OVF_EN (registered S3_Ovf flag).
// ---------------------------------------------------------------------------
module stage3_execute
  import pipe_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  stage3_execute_if.slave   bus
);

  logic [N-1:0]        op_b;
  logic [N-1:0]        alu_result;
  logic                alu_zero;

  logic [N-1:0]        alu_out_q, alu_out_d;
  logic [REGSEL_W-1:0] ws_q, ws_d;
  logic                we_q, we_d;
  logic                zero_q, zero_d;
  logic [CNT_W-1:0]    retire_cnt_q, retire_cnt_d;

  // I-format instructions use the sign-extended immediate as operand B.
  assign op_b = (bus.S2_DS == DS_IMM) ?
                {{(N-IMM_W){bus.S2_IMM[IMM_W-1]}}, bus.S2_IMM} : bus.S2_RD2;

`ifdef ALU_OVF_EN
  logic alu_ovf;
  logic ovf_q, ovf_d;

  alu_core #(.N(N)) u_alu (
    .A      (bus.S2_RD1),
    .B      (op_b),
    .ALUOp  (bus.S2_ALUOp),
    .Result (alu_result),
    .Zero   (alu_zero),
    .Ovf    (alu_ovf)
  );
`else
  alu_core #(.N(N)) u_alu (
    .A      (bus.S2_RD1),
    .B      (op_b),
    .ALUOp  (bus.S2_ALUOp),
    .Result (alu_result),
    .Zero   (alu_zero)
  );
`endif

  // A stall holds everything, including S3_WE, so the register file simply
  // rewrites the same value until the stage advances.
  always_comb begin
    alu_out_d    = alu_out_q;
    ws_d         = ws_q;
    we_d         = we_q;
    zero_d       = zero_q;
    retire_cnt_d = retire_cnt_q;
    if (bus.WriteEnable) begin
      alu_out_d = alu_result;
      ws_d      = bus.S2_WS;
      we_d      = bus.S2_WE;
      zero_d    = alu_zero;
      if (bus.S2_WE)
        retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      alu_out_q    <= '0;
      ws_q         <= '0;
      we_q         <= 1'b0;
      zero_q       <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      alu_out_q    <= alu_out_d;
      ws_q         <= ws_d;
      we_q         <= we_d;
      zero_q       <= zero_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

`ifdef ALU_OVF_EN
  always_comb begin
    ovf_d = ovf_q;
    if (bus.WriteEnable)
      ovf_d = alu_ovf;
  end

  always_ff @(posedge Clk) begin
    if (Reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign bus.S3_Ovf = ovf_q;
`endif

  assign bus.S3_ALUOut   = alu_out_q;
  assign bus.S3_WS       = ws_q;
  assign bus.S3_WE       = we_q;
  assign bus.S3_Zero     = zero_q;
  assign bus.RetireCount = retire_cnt_q;

endmodule

// File: tb/tb_stage3_execute.sv
// ---------------------------------------------------------------------------
// tb_stage3_execute
// Self-checking bench for stage3_execute (N=32, CNT_W=4 so the retire counter
// wraps quickly). A behavioural model predicts the Stage3 register contents
// from the instruction semantics; every negedge the DUT outputs are compared
// against it, and a few hand-computed literals pin the model.
// Optional feature macro: ALU_OVF_EN (adds S3_Ovf checks).
// ---------------------------------------------------------------------------
module tb_stage3_execute;
  import pipe_pkg::*;

  localparam int N     = 32;
  localparam int CNT_W = 4;
  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -MAX_S - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   chkEn = 1'b0;

  // model state: what the Stage3 register must hold
  logic [31:0] mOut = '0;
  logic [4:0]  mWs = '0;
  logic        mWe = 1'b0;
  logic        mZero = 1'b0;
  logic        mOvf = 1'b0;
  int          mCnt = 0;

  stage3_execute_if #(.N(N), .CNT_W(CNT_W)) bus ();

  stage3_execute #(.N(N), .CNT_W(CNT_W)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU using wide signed arithmetic: wrap and overflow fall out of
  // comparing the exact mathematical result with the 32-bit range.
  function automatic logic [31:0] aluModel(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           output logic ovf);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint r;
    logic [31:0] res;
    ovf = 1'b0;
    res = '0;
    case (op)
      3'd0: res = a;
      3'd1: res = 32'hFFFF_FFFF - a;
      3'd2: begin r = sa + sb; res = r[31:0]; ovf = (r > MAX_S) || (r < MIN_S); end
      3'd3: begin r = sa - sb; res = r[31:0]; ovf = (r > MAX_S) || (r < MIN_S); end
      3'd4: res = a | b;
      3'd5: res = a & b;
      3'd6: res = a ^ b;
      default: res = (sa < sb) ? 32'd1 : 32'd0;
    endcase
    return res;
  endfunction

  // Model advances on the same edge as the DUT, reading the settled inputs.
  always @(posedge clk) begin
    logic [31:0] b;
    logic        ovf;
    if (reset) begin
      mOut = '0; mWs = '0; mWe = 1'b0; mZero = 1'b0; mOvf = 1'b0; mCnt = 0;
    end else if (bus.WriteEnable) begin
      b     = bus.S2_DS ? 32'($signed(bus.S2_IMM)) : bus.S2_RD2;
      mOut  = aluModel(bus.S2_ALUOp, bus.S2_RD1, b, ovf);
      mOvf  = ovf;
      mZero = (mOut == 32'd0);
      mWs   = bus.S2_WS;
      mWe   = bus.S2_WE;
      if (bus.S2_WE) mCnt = (mCnt + 1) % (1 << CNT_W);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Continuous compare against the model away from the active edge.
  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("S3_ALUOut", 64'(bus.S3_ALUOut), 64'(mOut));
      checkOutput("S3_WS", 64'(bus.S3_WS), 64'(mWs));
      checkOutput("S3_WE", 64'(bus.S3_WE), 64'(mWe));
      checkOutput("S3_Zero", 64'(bus.S3_Zero), 64'(mZero));
      checkOutput("RetireCount", 64'(bus.RetireCount), 64'(mCnt));
`ifdef ALU_OVF_EN
      checkOutput("S3_Ovf", 64'(bus.S3_Ovf), 64'(mOvf));
`endif
    end
  end

  task automatic applyStimulus(input logic rst, input logic wen,
                               input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic [15:0] imm, input logic ds,
                               input logic [2:0] op, input logic [4:0] ws,
                               input logic s2we);
    reset           = rst;
    bus.WriteEnable = wen;
    bus.S2_RD1      = rd1;
    bus.S2_RD2      = rd2;
    bus.S2_IMM      = imm;
    bus.S2_DS       = ds;
    bus.S2_ALUOp    = op;
    bus.S2_WS       = ws;
    bus.S2_WE       = s2we;
    @(posedge clk);
    #1;
  endtask

  task automatic applyRandom(input logic rst, input logic wen, input logic s2we);
    logic [31:0] rd1 = $urandom;
    logic [31:0] rd2 = ($urandom_range(0, 7) == 0) ? rd1 : $urandom;
    applyStimulus(rst, wen, rd1, rd2, 16'($urandom), 1'($urandom),
                  3'($urandom), 5'($urandom), s2we);
  endtask

  initial begin
    // reset with every input nonzero
    applyStimulus(1, 1, 32'hFFFF_FFFF, 32'h1234, 16'hFFFF, 1, ALU_ADD, 5'd31, 1);
    chkEn = 1'b1;
    applyStimulus(1, 1, 32'hFFFF_FFFF, 32'h1234, 16'hFFFF, 1, ALU_ADD, 5'd31, 1);
    checkOutput("rst_out", 64'(bus.S3_ALUOut), 64'h0);
    checkOutput("rst_ws", 64'(bus.S3_WS), 64'h0);
    checkOutput("rst_we", 64'(bus.S3_WE), 64'h0);
    checkOutput("rst_zero", 64'(bus.S3_Zero), 64'h0);
    checkOutput("rst_cnt", 64'(bus.RetireCount), 64'h0);

    // R-format ADD
    applyStimulus(0, 1, 32'h5, 32'h3, 16'h0, DS_REG, ALU_ADD, 5'd7, 1);
    checkOutput("radd_out", 64'(bus.S3_ALUOut), 64'h8);
    checkOutput("radd_ws", 64'(bus.S3_WS), 64'h7);
    checkOutput("radd_we", 64'(bus.S3_WE), 64'h1);
    checkOutput("radd_cnt", 64'(bus.RetireCount), 64'h1);
    checkOutput("model_radd", 64'(mOut), 64'h8);

    // I-format sign extension
    applyStimulus(0, 1, 32'h10, 32'h0, 16'hFFFF, DS_IMM, ALU_ADD, 5'd2, 1);
    checkOutput("iadd_out", 64'(bus.S3_ALUOut), 64'hF);
    applyStimulus(0, 1, 32'hFFFF_FFFE, 32'h0, 16'hFFFF, DS_IMM, ALU_SLT, 5'd3, 1);
    checkOutput("slt_out", 64'(bus.S3_ALUOut), 64'h1);
    checkOutput("model_slt", 64'(mOut), 64'h1);

    // zero flag and wrap/overflow
    applyStimulus(0, 1, 32'h1234_5678, 32'h1234_5678, 16'h0, DS_REG, ALU_SUB, 5'd4, 1);
    checkOutput("sub_out", 64'(bus.S3_ALUOut), 64'h0);
    checkOutput("sub_zero", 64'(bus.S3_Zero), 64'h1);
    applyStimulus(0, 1, 32'h7FFF_FFFF, 32'h0, 16'h0001, DS_IMM, ALU_ADD, 5'd5, 1);
    checkOutput("wrap_out", 64'(bus.S3_ALUOut), 64'h8000_0000);
    checkOutput("wrap_zero", 64'(bus.S3_Zero), 64'h0);
`ifdef ALU_OVF_EN
    checkOutput("wrap_ovf", 64'(bus.S3_Ovf), 64'h1);
    checkOutput("model_ovf", 64'(mOvf), 64'h1);
`endif

    // stall holds XOR result and counter
    applyStimulus(0, 1, 32'hA5A5_A5A5, 32'h0, 16'h0, DS_REG, ALU_XOR, 5'd9, 1);
    checkOutput("xor_out", 64'(bus.S3_ALUOut), 64'hA5A5_A5A5);
    for (int i = 0; i < 3; i++) applyRandom(0, 0, 1);
    checkOutput("stall_out", 64'(bus.S3_ALUOut), 64'hA5A5_A5A5);
    checkOutput("stall_ws", 64'(bus.S3_WS), 64'h9);
    checkOutput("stall_we", 64'(bus.S3_WE), 64'h1);
    checkOutput("stall_cnt", 64'(bus.RetireCount), 64'h6);
    applyStimulus(0, 1, 32'h55, 32'h0, 16'h0, DS_REG, ALU_MOV, 5'd1, 1);
    checkOutput("resume_out", 64'(bus.S3_ALUOut), 64'h55);
    checkOutput("resume_cnt", 64'(bus.RetireCount), 64'h7);

    // counter wrap after 2^CNT_W writes
    applyRandom(1, 1, 1);
    for (int i = 0; i < 16; i++) applyRandom(0, 1, 1);
    checkOutput("wrap_cnt", 64'(bus.RetireCount), 64'h0);
    applyRandom(0, 1, 1);
    checkOutput("cnt_one", 64'(bus.RetireCount), 64'h1);

    // reset beats WriteEnable
    applyRandom(1, 1, 1);
    checkOutput("rstpri_we", 64'(bus.S3_WE), 64'h0);
    checkOutput("rstpri_cnt", 64'(bus.RetireCount), 64'h0);

    // randomized traffic checked by the compare process
    for (int i = 0; i < 400; i++)
      applyRandom(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), 1'($urandom));

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
